// File: rtl/i2_router_fifo_rdctrl.sv
// i2_router_fifo_rdctrl: read-side controller for the i2 router input FIFO.
//   Pops flits, checks packet framing (head then PKT_LEN-1 bodies) and drives
//   survivors downstream through a 2-entry buffer with a req/busy handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   FIFO_empty/FIFO_rd  FIFO status and pop request
//   FIFO_dout           FIFO read data, valid the cycle after FIFO_rd
//   output_req/data     downstream flit valid and value
//   output_bussy        downstream stall
//   pkt_sent            pulse when a packet's last flit is accepted
//   framing_err         pulse when a flit fails the framing check
//   err_cnt             saturating error count (only with I2_ROUTER_RDCTRL_ERRCNT_EN)
module i2_router_fifo_rdctrl #(
  parameter int FLIT_W = 16,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FIFO_empty,
  input  logic [FLIT_W-1:0] FIFO_dout,
  output logic              FIFO_rd,
  output logic              output_req,
  output logic [FLIT_W-1:0] output_data,
  input  logic              output_bussy,
  output logic              pkt_sent,
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
  output logic              framing_err,
  output logic [7:0]        err_cnt
`else
  output logic              framing_err
`endif
);
  typedef enum logic {WAIT_HEAD, IN_PKT} state_t;
  localparam logic [3:0] CNT_INIT = 4'(PKT_LEN - 1);
  state_t state, nstate;
  logic [3:0] cnt, ncnt;
  logic [1:0] occ;
  logic [2:0] room;
  logic rd_pend, pop, enq, elast, l0, l1;
  logic [FLIT_W-1:0] d0, d1;
  logic [2:0] typ;
  assign typ = FIFO_dout[FLIT_W-1:FLIT_W-3];
  assign output_req = occ != 2'd0;
  assign output_data = d0;
  assign pop = output_req && !output_bussy;
  assign pkt_sent = pop && l0 && !rst;
  // Entries already committed once this cycle's pop and in-flight read settle.
  assign room = {1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop};
  assign FIFO_rd = !rst && !FIFO_empty && room < 3'd2;
  always_comb begin
    nstate = state;
    ncnt = cnt;
    enq = 1'b0;
    elast = 1'b0;
    framing_err = 1'b0;
    if (rd_pend && !rst)
      case (state)
        WAIT_HEAD: begin
          enq = typ == 3'b001;
          framing_err = typ != 3'b001;
          nstate = typ == 3'b001 ? IN_PKT : WAIT_HEAD;
          ncnt = typ == 3'b001 ? CNT_INIT : cnt;
        end
        default: begin
          enq = typ == 3'b110 || typ == 3'b001;
          framing_err = typ != 3'b110;
          elast = typ == 3'b110 && cnt == 4'd1;
          ncnt = typ == 3'b110 ? cnt - 4'd1 : typ == 3'b001 ? CNT_INIT : cnt;
          nstate = typ == 3'b001 ? IN_PKT : (typ != 3'b110 || cnt == 4'd1) ? WAIT_HEAD : IN_PKT;
        end
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= WAIT_HEAD;
      cnt <= '0;
      rd_pend <= 1'b0;
      occ <= '0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      rd_pend <= FIFO_rd;
      occ <= occ + {1'b0, enq} - {1'b0, pop};
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      // New entry lands in the slot just past the survivors of this cycle's pop.
      if (enq && occ == {1'b0, pop}) begin
        d0 <= FIFO_dout;
        l0 <= elast;
      end else if (enq) begin
        d1 <= FIFO_dout;
        l1 <= elast;
      end
    end
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (framing_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_i2_router_fifo_rdctrl.sv
// tb_i2_router_fifo_rdctrl: directed self-checking bench for i2_router_fifo_rdctrl.
module tb_i2_router_fifo_rdctrl;
  logic clk = 1'b0, rst = 1'b1, output_bussy = 1'b0;
  logic FIFO_empty, FIFO_rd, output_req, pkt_sent, framing_err;
  logic [15:0] FIFO_dout = '0, output_data;
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
  logic [7:0] err_cnt;
`endif
  i2_router_fifo_rdctrl dut (
    .clk(clk), .rst(rst), .FIFO_empty(FIFO_empty), .FIFO_dout(FIFO_dout), .FIFO_rd(FIFO_rd),
    .output_req(output_req), .output_data(output_data), .output_bussy(output_bussy),
    .pkt_sent(pkt_sent),
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    .framing_err(framing_err), .err_cnt(err_cnt)
`else
    .framing_err(framing_err)
`endif
  );
  always #5 clk = ~clk;
  logic [15:0] mem [0:63];
  int wp = 0, rp = 0;
  assign FIFO_empty = rp == wp;
  always @(posedge clk)
    if (FIFO_rd && !FIFO_empty) begin
      FIFO_dout <= mem[rp];
      rp <= rp + 1;
    end
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) if (FIFO_rd) check("rd_while_empty", 32'(FIFO_empty), 32'd0);
  logic [15:0] dq[$];
  int ps_n, fe_n, c;
  logic [15:0] ps_data;
  logic w_rd[32], w_req[32], w_ps[32];
  logic [15:0] w_data[32];
  function automatic logic [15:0] hd(input int k);
    return {3'b001, 13'(k)};
  endfunction
  function automatic logic [15:0] bd(input int k);
    return {3'b110, 13'(k)};
  endfunction
  task automatic clr();
    dq.delete();
    ps_n = 0;
    fe_n = 0;
    c = 0;
  endtask
  task automatic push(input logic [15:0] f);
    mem[wp] = f;
    wp++;
  endtask
  task automatic cyc(input logic bz);
    output_bussy = bz;
    @(negedge clk);
    w_rd[c] = FIFO_rd;
    w_req[c] = output_req;
    w_data[c] = output_data;
    w_ps[c] = pkt_sent;
    if (output_req && !output_bussy) dq.push_back(output_data);
    if (pkt_sent) begin
      ps_n++;
      ps_data = output_data;
    end
    if (framing_err) fe_n++;
    c++;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_q(input string tag, input logic [15:0] e[$]);
    check({tag, "_count"}, 32'(dq.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      check(tag, i < dq.size() ? 32'(dq[i]) : 32'hdeadbeef, 32'(e[i]));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", 32'(output_req), 32'd0);
    check("rst_rd", 32'(FIFO_rd), 32'd0);
    check("rst_data", 32'(output_data), 32'd0);
    check("rst_ps", 32'(pkt_sent), 32'd0);
    check("rst_fe", 32'(framing_err), 32'd0);
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    check("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    // single packet, no backpressure
    clr();
    push(hd(1)); push(bd(2)); push(bd(3)); push(bd(4));
    for (int i = 0; i < 8; i++) cyc(1'b0);
    for (int i = 0; i < 8; i++) begin
      check("t1_rd", 32'(w_rd[i]), 32'(i < 4));
      check("t1_req", 32'(w_req[i]), 32'(i >= 2 && i <= 5));
      check("t1_ps", 32'(w_ps[i]), 32'(i == 5));
    end
    chk_q("t1_seq", '{hd(1), bd(2), bd(3), bd(4)});
    // backpressure on cycles 2..6
    clr();
    push(hd(10)); push(bd(11)); push(bd(12)); push(bd(13));
    for (int i = 0; i < 12; i++) cyc(i >= 2 && i <= 6);
    for (int i = 0; i < 12; i++) begin
      check("t2_rd", 32'(w_rd[i]), 32'(i < 2 || i == 7 || i == 8));
      check("t2_req", 32'(w_req[i]), 32'(i >= 2 && i <= 10));
      check("t2_ps", 32'(w_ps[i]), 32'(i == 10));
    end
    for (int i = 2; i <= 7; i++) check("t2_hold", 32'(w_data[i]), 32'(hd(10)));
    chk_q("t2_seq", '{hd(10), bd(11), bd(12), bd(13)});
    // leading body flit dropped
    clr();
    push(bd(20)); push(hd(21)); push(bd(22)); push(bd(23)); push(bd(24));
    for (int i = 0; i < 10; i++) cyc(1'b0);
    check("t3_fe", 32'(fe_n), 32'd1);
    check("t3_ps", 32'(ps_n), 32'd1);
    chk_q("t3_seq", '{hd(21), bd(22), bd(23), bd(24)});
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    check("t3_errcnt", 32'(err_cnt), 32'd1);
`endif
    // truncated packet restarted by a new head
    clr();
    push(hd(30)); push(bd(31)); push(hd(32)); push(bd(33)); push(bd(34)); push(bd(35));
    for (int i = 0; i < 12; i++) cyc(1'b0);
    check("t4_fe", 32'(fe_n), 32'd1);
    check("t4_ps", 32'(ps_n), 32'd1);
    check("t4_ps_flit", 32'(ps_data), 32'(bd(35)));
    chk_q("t4_seq", '{hd(30), bd(31), hd(32), bd(33), bd(34), bd(35)});
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    check("t4_errcnt", 32'(err_cnt), 32'd2);
`endif
    // illegal type mid-packet, then a clean packet
    clr();
    push(hd(40)); push(bd(41)); push({3'b011, 13'd42});
    push(hd(43)); push(bd(44)); push(bd(45)); push(bd(46));
    for (int i = 0; i < 14; i++) cyc(1'b0);
    check("t5_fe", 32'(fe_n), 32'd1);
    check("t5_ps", 32'(ps_n), 32'd1);
    check("t5_ps_flit", 32'(ps_data), 32'(bd(46)));
    chk_q("t5_seq", '{hd(40), bd(41), hd(43), bd(44), bd(45), bd(46)});
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    check("t5_errcnt", 32'(err_cnt), 32'd3);
`endif
    // reset with a buffered entry and a read in flight
    clr();
    push(hd(50)); push(bd(51));
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    cyc(1'b0);
    check("t6_req_before", 32'(w_req[2]), 32'd1);
    check("t6_req_after", 32'(w_req[3]), 32'd0);
    check("t6_fe", 32'(fe_n), 32'd0);
`ifdef I2_ROUTER_RDCTRL_ERRCNT_EN
    check("t6_errcnt", 32'(err_cnt), 32'd0);
`endif
    clr();
    push(hd(60)); push(bd(61)); push(bd(62)); push(bd(63));
    for (int i = 0; i < 8; i++) cyc(1'b0);
    check("t6_rd0", 32'(w_rd[0]), 32'd1);
    check("t6_req1", 32'(w_req[1]), 32'd0);
    check("t6_req2", 32'(w_req[2]), 32'd1);
    check("t6_data2", 32'(w_data[2]), 32'(hd(60)));
    check("t6_ps", 32'(ps_n), 32'd1);
    chk_q("t6_seq", '{hd(60), bd(61), bd(62), bd(63)});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
